boss_bullet_array: RTL and testbench
====================================

BOSS_BULLET_ARRAY -- requirements
Module: boss_bullet_array

Interface
REQ-001 The block SHALL have parameter NUM_BULLETS, default 8, meaning the number of bullet slots (range 2..16, even).
REQ-002 The block SHALL have parameter COORD_W, default 10, meaning the coordinate width in bits.
REQ-003 The block SHALL have parameter FIRE_PERIOD, default 32, meaning the number of clk22 cycles between volleys.
REQ-004 The block SHALL have parameter HIT_R, default 11, meaning the hit-box half-size in pixels.
REQ-005 The block SHALL have ports: clk22 input 1, single clock; rst_n input 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have ports: boss input 1, boss phase active; gamestart input 1, synchronous clear.
REQ-007 The block SHALL have ports: mode input 2, pattern select (0 fan, 1 aimed, 2 rain, 3 reserved=fan).
REQ-008 The block SHALL have ports: bossx, bossy, reimux, reimuy input COORD_W each, positions.
REQ-009 The block SHALL have ports: bullet_valid output NUM_BULLETS, one bit per live slot; bullet_x, bullet_y output NUM_BULLETS*COORD_W each, packed with slot i at bits [i*COORD_W +: COORD_W].
REQ-010 The block SHALL have ports: shot output 1, one-cycle hit pulse; hit_cnt output 8, saturating hit counter.

Function
REQ-011 Each slot SHALL run FSM IDLE -> FLY -> IDLE; FLY is left by hit or exit.
REQ-012 The tick counter SHALL count 0..FIRE_PERIOD-1 and wrap; a volley SHALL fire on the wrap cycle when boss=1 and gamestart=0.
REQ-013 On volley, every IDLE slot SHALL enter FLY next cycle at (bossx, bossy) with velocity latched at that cycle; FLY slots SHALL be unaffected.
REQ-014 Velocity SHALL be signed 6-bit dx, dy; fan: dx_i = 2*i-(NUM_BULLETS-1), dy=4.
REQ-015 Aimed: dx = (reimux-bossx) arithmetic >>4, clamped to +/-8, dy=5, same for all slots.
REQ-016 Rain: dx=0, dy = 6+(i mod 4).
REQ-017 A FLY slot SHALL update pos <= pos + vel each cycle, computed at COORD_W+1 bits signed.
REQ-018 Hit SHALL be when x+HIT_R > reimux, x < reimux+HIT_R, y+HIT_R > reimuy and y < reimuy+HIT_R, at COORD_W+1 bits with no underflow.
REQ-019 Exit SHALL be when the next y < 8 or > 472, or the next x < 8 or > 432.
REQ-020 Hit SHALL take precedence over exit and move; a hit or exit slot SHALL go IDLE next cycle with valid=0 and position parked at (bossx, bossy).
REQ-021 shot SHALL be the registered OR of all slot hits, 1-cycle latency; simultaneous hits SHALL produce one pulse and one hit_cnt increment.
REQ-022 hit_cnt SHALL saturate at 255.
REQ-023 boss=0 or gamestart=1 SHALL force all slots IDLE, tick=0, and shot=0 on the next edge; hit_cnt SHALL be cleared by gamestart only.
REQ-024 A volley coinciding with a slot retiring SHALL NOT relaunch that slot in the same cycle; it relaunches next volley.

Reset
REQ-025 rst_n low SHALL asynchronously set all slots IDLE, bullet_valid=0, bullet_x=bullet_y=0, velocities=0, tick=0, shot=0, hit_cnt=0.
REQ-026 rst_n deassertion mid-flight SHALL restart cleanly with the first volley FIRE_PERIOD cycles later.

Configuration
REQ-027 With BOSS_BULLET_BOUNCE_EN defined, an x-exit SHALL instead negate dx and clamp x to 8 or 432 (y-exit still retires).
REQ-028 Without BOSS_BULLET_BOUNCE_EN, any exit SHALL retire the slot.

Structure
REQ-029 Package boss_bullet_pkg SHALL hold field limits (8, 432, 8, 472), the mode enum, slot-state enum and velocity typedef.
REQ-030 One sub-module, bullet_slot (FSM, position, velocity, hit/exit per slot), SHALL be instantiated NUM_BULLETS times.
REQ-031 The top SHALL hold the tick counter, velocity generation, shot/hit_cnt logic and packing.

Verification
REQ-032 Scenario: boss=1, mode=0, bossx=220, bossy=40, reimu far -> at tick wrap, 8 valid; after 1 move slot0 is at x=213, y=44.
REQ-033 Scenario: mode=1, bossx=100, reimux=300 -> dx=8 for all slots (clamped from 12).
REQ-034 Scenario: slot at y=468, dy=6 -> retires, valid=0 next cycle, no shot.
REQ-035 Scenario: two slots overlapping reimu (220, 60) in the same cycle -> one shot pulse and hit_cnt +1.
REQ-036 Scenario: BOSS_BULLET_BOUNCE_EN, x=10, dx=-7 -> x clamps to 8 and dx=+7; without the macro the slot retires.
REQ-037 Scenario: rst_n pulsed low mid-cycle during flight -> outputs go 0 immediately, without waiting for clk22.

Source files
------------

// File: rtl/boss_bullet_pkg.sv
// Shared definitions for the boss bullet array: playfield limits, pattern
// select, per-slot state and the signed velocity type.
package boss_bullet_pkg;

    // Playfield limits; a bullet whose next position leaves this box exits.
    localparam int unsigned X_MIN = 8;
    localparam int unsigned X_MAX = 432;
    localparam int unsigned Y_MIN = 8;
    localparam int unsigned Y_MAX = 472;

    typedef enum logic [1:0] {
        ModeFan   = 2'd0,
        ModeAimed = 2'd1,
        ModeRain  = 2'd2,
        ModeRsvd  = 2'd3
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StFly  = 1'b1
    } slot_state_e;

    typedef logic signed [5:0] vel_t;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLY state machine, position and velocity registers,
// hit detection against the player and playfield exit detection.
// Optional feature macro: BOSS_BULLET_BOUNCE_EN (x-exit reflects instead of retiring).
module bullet_slot
    import boss_bullet_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned HIT_R   = 11
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_launch,
    input  vel_t               i_dx,
    input  vel_t               i_dy,
    input  logic [COORD_W-1:0] i_bossx,
    input  logic [COORD_W-1:0] i_bossy,
    input  logic [COORD_W-1:0] i_reimux,
    input  logic [COORD_W-1:0] i_reimuy,
    output logic               o_valid,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_hit
);

    localparam int unsigned W = COORD_W + 1;
    localparam logic signed [W-1:0] XLo  = $signed(W'(X_MIN));
    localparam logic signed [W-1:0] XHi  = $signed(W'(X_MAX));
    localparam logic signed [W-1:0] YLo  = $signed(W'(Y_MIN));
    localparam logic signed [W-1:0] YHi  = $signed(W'(Y_MAX));
    localparam logic [W-1:0]        HitR = W'(HIT_R);

    slot_state_e         r_state;
    slot_state_e         w_state_next;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    vel_t                r_dx;
    vel_t                r_dy;
    logic signed [W-1:0] w_nx;
    logic signed [W-1:0] w_ny;
    logic                w_hit;
    logic                w_xexit;
    logic                w_yexit;
    logic                w_retire;

    // Next position with one guard bit so leaving through zero reads as negative.
    assign w_nx = $signed({1'b0, r_x}) + W'(r_dx);
    assign w_ny = $signed({1'b0, r_y}) + W'(r_dy);

    // Overlap test only adds to either side, so nothing can underflow.
    assign w_hit = (r_state == StFly)
                && (({1'b0, r_x} + HitR) > {1'b0, i_reimux})
                && ({1'b0, r_x} < ({1'b0, i_reimux} + HitR))
                && (({1'b0, r_y} + HitR) > {1'b0, i_reimuy})
                && ({1'b0, r_y} < ({1'b0, i_reimuy} + HitR));

    assign w_xexit = (w_nx < XLo) || (w_nx > XHi);
    assign w_yexit = (w_ny < YLo) || (w_ny > YHi);

`ifdef BOSS_BULLET_BOUNCE_EN
    assign w_retire = w_hit || w_yexit;
`else
    assign w_retire = w_hit || w_yexit || w_xexit;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    // Next-state: launch only from IDLE, so a retiring slot waits for the next volley
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (i_launch) w_state_next = StFly;
                StFly:   if (w_retire) w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Position/velocity: load on launch, move while flying, park at the boss on retire
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_dx <= '0;
            r_dy <= '0;
        end else if (!i_clear) begin
            if (r_state == StIdle) begin
                if (i_launch) begin
                    r_x  <= i_bossx;
                    r_y  <= i_bossy;
                    r_dx <= i_dx;
                    r_dy <= i_dy;
                end
            end else if (w_retire) begin
                r_x <= i_bossx;
                r_y <= i_bossy;
            end else begin
                r_y <= w_ny[COORD_W-1:0];
`ifdef BOSS_BULLET_BOUNCE_EN
                if (w_xexit) begin
                    r_x  <= (w_nx < XLo) ? XLo[COORD_W-1:0] : XHi[COORD_W-1:0];
                    r_dx <= -r_dx;
                end else begin
                    r_x <= w_nx[COORD_W-1:0];
                end
`else
                r_x <= w_nx[COORD_W-1:0];
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        o_valid = (r_state == StFly);
        o_x     = r_x;
        o_y     = r_y;
        o_hit   = w_hit;
    end

endmodule

// File: rtl/boss_bullet_array.sv
// Boss bullet array: volley timer, per-pattern velocity generation, hit pulse
// and saturating hit counter around NUM_BULLETS bullet_slot instances.
// Optional feature macro: BOSS_BULLET_BOUNCE_EN (handled inside bullet_slot).
module boss_bullet_array
    import boss_bullet_pkg::*;
#(
    parameter int unsigned NUM_BULLETS = 8,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned FIRE_PERIOD = 32,
    parameter int unsigned HIT_R       = 11
) (
    input  logic                           clk22,
    input  logic                           rst_n,
    input  logic                           boss,
    input  logic                           gamestart,
    input  logic [1:0]                     mode,
    input  logic [COORD_W-1:0]             bossx,
    input  logic [COORD_W-1:0]             bossy,
    input  logic [COORD_W-1:0]             reimux,
    input  logic [COORD_W-1:0]             reimuy,
    output logic [NUM_BULLETS-1:0]         bullet_valid,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
    output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
    output logic                           shot,
    output logic [7:0]                     hit_cnt
);

    localparam int unsigned TickW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(FIRE_PERIOD - 1);
    localparam int unsigned W = COORD_W + 1;
    localparam logic signed [W-1:0] AimMax = W'(8);
    localparam logic signed [W-1:0] AimMin = -AimMax;

    logic [TickW-1:0]       r_tick;
    logic                   r_shot;
    logic [7:0]             r_hit_cnt;
    logic                   w_clear;
    logic                   w_volley;
    logic                   w_any_hit;
    logic [NUM_BULLETS-1:0] w_hits;
    logic signed [W-1:0]    w_diff;
    logic signed [W-1:0]    w_aim;
    vel_t                   w_aim_dx;
    vel_t                   w_dx [NUM_BULLETS];
    vel_t                   w_dy [NUM_BULLETS];

    assign w_clear   = ~boss | gamestart;
    assign w_volley  = boss & ~gamestart & (r_tick == TickLast);
    assign w_any_hit = (|w_hits) & ~w_clear;

    // Volley timer wraps every FIRE_PERIOD cycles and holds at zero outside the boss phase
    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n)                 r_tick <= '0;
        else if (w_clear)           r_tick <= '0;
        else if (r_tick == TickLast) r_tick <= '0;
        else                        r_tick <= r_tick + 1'b1;
    end

    // Aimed dx: horizontal offset to the player, floored /16, clamped to +/-8
    assign w_diff = $signed({1'b0, reimux}) - $signed({1'b0, bossx});
    assign w_aim  = w_diff >>> 4;

    always_comb begin
        w_aim_dx = vel_t'(w_aim);
        if (w_aim > AimMax)      w_aim_dx = vel_t'(AimMax);
        else if (w_aim < AimMin) w_aim_dx = vel_t'(AimMin);
    end

    // Per-slot launch velocity for the selected pattern; reserved mode fires a fan
    always_comb begin
        for (int i = 0; i < int'(NUM_BULLETS); i++) begin
            w_dx[i] = vel_t'(2 * i - (int'(NUM_BULLETS) - 1));
            w_dy[i] = vel_t'(4);
            case (mode_e'(mode))
                ModeAimed: begin
                    w_dx[i] = w_aim_dx;
                    w_dy[i] = vel_t'(5);
                end
                ModeRain: begin
                    w_dx[i] = '0;
                    w_dy[i] = vel_t'(6 + (i % 4));
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .COORD_W (COORD_W),
            .HIT_R   (HIT_R)
        ) u_slot (
            .i_clk    (clk22),
            .i_rst_n  (rst_n),
            .i_clear  (w_clear),
            .i_launch (w_volley),
            .i_dx     (w_dx[g]),
            .i_dy     (w_dy[g]),
            .i_bossx  (bossx),
            .i_bossy  (bossy),
            .i_reimux (reimux),
            .i_reimuy (reimuy),
            .o_valid  (bullet_valid[g]),
            .o_x      (bullet_x[g*COORD_W +: COORD_W]),
            .o_y      (bullet_y[g*COORD_W +: COORD_W]),
            .o_hit    (w_hits[g])
        );
    end

    // Any number of same-cycle hits yields one shot pulse and one count
    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            r_shot    <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_shot <= w_any_hit;
            if (gamestart)                           r_hit_cnt <= '0;
            else if (w_any_hit && r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
        end
    end

    assign shot    = r_shot;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_boss_bullet_array.sv
// Directed self-checking bench for boss_bullet_array (default parameters).
// Honours BOSS_BULLET_BOUNCE_EN when compiled with it.
module tb_boss_bullet_array;

    localparam int CW = 10;

    logic        clk22 = 1'b0;
    logic        rst_n;
    logic        boss;
    logic        gamestart;
    logic [1:0]  mode;
    logic [9:0]  bossx, bossy, reimux, reimuy;
    logic [7:0]  bullet_valid;
    logic [79:0] bullet_x, bullet_y;
    logic        shot;
    logic [7:0]  hit_cnt;

    int checks = 0;
    int errors = 0;

    boss_bullet_array u_dut (
        .clk22        (clk22),
        .rst_n        (rst_n),
        .boss         (boss),
        .gamestart    (gamestart),
        .mode         (mode),
        .bossx        (bossx),
        .bossy        (bossy),
        .reimux       (reimux),
        .reimuy       (reimuy),
        .bullet_valid (bullet_valid),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .shot         (shot),
        .hit_cnt      (hit_cnt)
    );

    always #5 clk22 = ~clk22;

    task automatic step();
        @(posedge clk22);
        #1;
    endtask

    // Clear with gamestart, then run to the first volley (32 edges later).
    task automatic launch();
        gamestart = 1'b1;
        step();
        gamestart = 1'b0;
        repeat (32) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; boss = 1'b0; gamestart = 1'b0; mode = 2'd0;
        bossx = 10'd0; bossy = 10'd0; reimux = 10'd1000; reimuy = 10'd1000;
        #3;
        checks++; if (bullet_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want 00", bullet_valid); end
        checks++; if (bullet_x !== 80'h0) begin errors++; $display("FAIL reset_x got %h want 0", bullet_x); end
        checks++; if (bullet_y !== 80'h0) begin errors++; $display("FAIL reset_y got %h want 0", bullet_y); end
        checks++; if (shot !== 1'b0) begin errors++; $display("FAIL reset_shot got %b want 0", shot); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hitcnt got %0d want 0", hit_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_fan();
        boss = 1'b1; mode = 2'd0; bossx = 10'd220; bossy = 10'd40;
        reimux = 10'd1000; reimuy = 10'd1000;
        launch();
        checks++; if (bullet_valid !== 8'hFF) begin errors++; $display("FAIL fan_valid got %h want ff", bullet_valid); end
        checks++; if (bullet_x[0 +: CW] !== 10'd220) begin errors++; $display("FAIL fan_launch_x0 got %0d want 220", bullet_x[0 +: CW]); end
        step();
        checks++; if (bullet_x[0 +: CW] !== 10'd213) begin errors++; $display("FAIL fan_x0 got %0d want 213", bullet_x[0 +: CW]); end
        checks++; if (bullet_y[0 +: CW] !== 10'd44) begin errors++; $display("FAIL fan_y0 got %0d want 44", bullet_y[0 +: CW]); end
        checks++; if (bullet_x[30 +: CW] !== 10'd219) begin errors++; $display("FAIL fan_x3 got %0d want 219", bullet_x[30 +: CW]); end
        checks++; if (bullet_x[70 +: CW] !== 10'd227) begin errors++; $display("FAIL fan_x7 got %0d want 227", bullet_x[70 +: CW]); end
    endtask

    task automatic test_aimed();
        mode = 2'd1; bossx = 10'd100; bossy = 10'd40; reimux = 10'd300; reimuy = 10'd1000;
        launch();
        step();
        checks++; if (bullet_x[0 +: CW] !== 10'd108) begin errors++; $display("FAIL aim_clamp_x0 got %0d want 108", bullet_x[0 +: CW]); end
        checks++; if (bullet_x[50 +: CW] !== 10'd108) begin errors++; $display("FAIL aim_clamp_x5 got %0d want 108", bullet_x[50 +: CW]); end
        checks++; if (bullet_y[0 +: CW] !== 10'd45) begin errors++; $display("FAIL aim_y0 got %0d want 45", bullet_y[0 +: CW]); end
        // -100 >>> 4 floors to -7
        reimux = 10'd0;
        launch();
        step();
        checks++; if (bullet_x[0 +: CW] !== 10'd93) begin errors++; $display("FAIL aim_neg_x0 got %0d want 93", bullet_x[0 +: CW]); end
    endtask

    task automatic test_exit_relaunch();
        mode = 2'd2; bossx = 10'd220; bossy = 10'd90; reimux = 10'd1000; reimuy = 10'd1000;
        launch();
        repeat (63) step();
        checks++; if (bullet_y[0 +: CW] !== 10'd468) begin errors++; $display("FAIL exit_pre_y0 got %0d want 468", bullet_y[0 +: CW]); end
        checks++; if (bullet_valid[0] !== 1'b1) begin errors++; $display("FAIL exit_pre_valid0 got %b want 1", bullet_valid[0]); end
        // Slots 0 and 4 retire on this volley edge; the rest relaunch.
        step();
        checks++; if (bullet_valid !== 8'hEE) begin errors++; $display("FAIL exit_valid got %h want ee", bullet_valid); end
        checks++; if (bullet_y[0 +: CW] !== 10'd90) begin errors++; $display("FAIL exit_park_y0 got %0d want 90", bullet_y[0 +: CW]); end
        checks++; if (shot !== 1'b0) begin errors++; $display("FAIL exit_shot got %b want 0", shot); end
        repeat (32) step();
        checks++; if (bullet_valid !== 8'hFF) begin errors++; $display("FAIL relaunch_valid got %h want ff", bullet_valid); end
    endtask

    task automatic test_double_hit();
        mode = 2'd2; bossx = 10'd220; bossy = 10'd40; reimux = 10'd220; reimuy = 10'd60;
        launch();
        step();
        // Slot 3 sits at y=49: 49+11 == 60 is not an overlap.
        checks++; if (shot !== 1'b0) begin errors++; $display("FAIL hit_edge_shot got %b want 0", shot); end
        step();
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL hit_pre_cnt got %0d want 0", hit_cnt); end
        step();
        checks++; if (shot !== 1'b1) begin errors++; $display("FAIL hit_shot got %b want 1", shot); end
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
        checks++; if (bullet_valid !== 8'h00) begin errors++; $display("FAIL hit_valid got %h want 00", bullet_valid); end
        step();
        checks++; if (shot !== 1'b0) begin errors++; $display("FAIL hit_pulse_end got %b want 0", shot); end
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL hit_cnt_hold got %0d want 1", hit_cnt); end
    endtask

    task automatic test_reset_midflight();
        int n;
        n = 0;
        while (bullet_valid == 8'h00 && n < 40) begin step(); n++; end
        checks++; if (bullet_valid !== 8'hFF) begin errors++; $display("FAIL mid_fly_valid got %h want ff", bullet_valid); end
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d want 1", hit_cnt); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bullet_valid !== 8'h00) begin errors++; $display("FAIL mid_valid got %h want 00", bullet_valid); end
        checks++; if (bullet_x !== 80'h0 || bullet_y !== 80'h0) begin errors++; $display("FAIL mid_pos got %h/%h want 0", bullet_x, bullet_y); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", hit_cnt); end
        step();
        rst_n = 1'b1;
        n = 0;
        while (bullet_valid == 8'h00 && n < 40) begin step(); n++; end
        checks++; if (n !== 32) begin errors++; $display("FAIL mid_first_volley got %0d want 32", n); end
    endtask

    task automatic test_x_exit();
        mode = 2'd0; bossx = 10'd220; bossy = 10'd40; reimux = 10'd1000; reimuy = 10'd1000;
        launch();
        repeat (30) step();
        checks++; if (bullet_x[0 +: CW] !== 10'd10) begin errors++; $display("FAIL xexit_pre_x0 got %0d want 10", bullet_x[0 +: CW]); end
        checks++; if (bullet_x[70 +: CW] !== 10'd430) begin errors++; $display("FAIL xexit_pre_x7 got %0d want 430", bullet_x[70 +: CW]); end
        step();
        checks++; if (bullet_x[10 +: CW] !== 10'd65) begin errors++; $display("FAIL xexit_x1 got %0d want 65", bullet_x[10 +: CW]); end
`ifdef BOSS_BULLET_BOUNCE_EN
        checks++; if (bullet_valid !== 8'hFF) begin errors++; $display("FAIL bounce_valid got %h want ff", bullet_valid); end
        checks++; if (bullet_x[0 +: CW] !== 10'd8) begin errors++; $display("FAIL bounce_x0 got %0d want 8", bullet_x[0 +: CW]); end
        checks++; if (bullet_x[70 +: CW] !== 10'd432) begin errors++; $display("FAIL bounce_x7 got %0d want 432", bullet_x[70 +: CW]); end
        step();
        checks++; if (bullet_x[0 +: CW] !== 10'd15) begin errors++; $display("FAIL bounce_next_x0 got %0d want 15", bullet_x[0 +: CW]); end
`else
        checks++; if (bullet_valid !== 8'h7E) begin errors++; $display("FAIL xexit_valid got %h want 7e", bullet_valid); end
        checks++; if (bullet_x[0 +: CW] !== 10'd220) begin errors++; $display("FAIL xexit_park_x0 got %0d want 220", bullet_x[0 +: CW]); end
`endif
        boss = 1'b0;
        step();
        checks++; if (bullet_valid !== 8'h00) begin errors++; $display("FAIL boss_off_valid got %h want 00", bullet_valid); end
    endtask

    initial begin
        test_reset();
        test_fan();
        test_aimed();
        test_exit_relaunch();
        test_double_hit();
        test_reset_midflight();
        test_x_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
